// File: rtl/recip_nr_ctrl.sv
// Newton-Raphson reciprocal iteration controller for bf16: seeds 1/D, runs ITER rounds
// through an external step unit, bypasses specials. Optional perf counters: RECIP_NR_PERF_CNT_EN.
module recip_nr_ctrl #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 7,
  parameter int FP_WIDTH       = 16,
  parameter int ITER           = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FP_WIDTH-1:0] in_d,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [FP_WIDTH-1:0] step_d,
  output logic [FP_WIDTH-1:0] step_xn,
  output logic                step_xn_valid,
  input  logic                step_xn_ready,
  input  logic [FP_WIDTH-1:0] step_xn1,
  input  logic                step_xn1_valid,
  output logic                step_xn1_ready,
  output logic [FP_WIDTH-1:0] res,
  output logic                res_valid,
  input  logic                res_ready
`ifdef RECIP_NR_PERF_CNT_EN
  ,
  output logic [15:0]         perf_done_cnt,
  output logic [15:0]         perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [EXP_WIDTH-1:0] EXP_ONES  = '1;
  // Seed exponent is EXP_FLUSH - E; at or above this the reciprocal underflows.
  localparam logic [EXP_WIDTH-1:0] EXP_FLUSH = EXP_ONES - EXP_WIDTH'(2);
  localparam logic [FP_WIDTH-1:0]  FP_NAN    =
    {1'b0, EXP_ONES, 1'b1, {(MANTISSA_WIDTH-1){1'b0}}};
  localparam logic [3:0]           LAST_CNT  = 4'((ITER == 0) ? 0 : ITER - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [FP_WIDTH-1:0] d_q, d_d;
  logic [FP_WIDTH-1:0] xn_q, xn_d;
  logic [FP_WIDTH-1:0] res_q, res_d;

  logic                      in_sign;
  logic [EXP_WIDTH-1:0]      in_exp;
  logic [MANTISSA_WIDTH-1:0] in_man;
  logic [FP_WIDTH-1:0]       seed;
  logic [FP_WIDTH-1:0]       special_res;
  logic                      is_special;

  assign in_sign = in_d[FP_WIDTH-1];
  assign in_exp  = in_d[FP_WIDTH-2 -: EXP_WIDTH];
  assign in_man  = in_d[MANTISSA_WIDTH-1:0];
  assign seed    = {in_sign, EXP_FLUSH - in_exp, ~in_man};

  // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    is_special  = 1'b1;
    special_res = {in_sign, {(FP_WIDTH-1){1'b0}}};
    if (in_exp == '0) begin
      special_res = {in_sign, EXP_ONES, {MANTISSA_WIDTH{1'b0}}};
    end else if (in_exp == EXP_ONES && in_man != '0) begin
      special_res = FP_NAN;
    end else if (in_exp < EXP_FLUSH) begin
      is_special = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      xn_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      xn_q    <= xn_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    xn_d    = xn_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          d_d = in_d;
          if (is_special) begin
            res_d   = special_res;
            state_d = S_DONE;
          end else if (ITER == 0) begin
            res_d   = seed;
            state_d = S_DONE;
          end else begin
            xn_d    = seed;
            cnt_d   = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (step_xn_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (step_xn1_valid) begin
          if (cnt_q == LAST_CNT) begin
            res_d   = step_xn1;
            state_d = S_DONE;
          end else begin
            xn_d    = step_xn1;
            cnt_d   = cnt_q + 4'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready       = (state_q == S_IDLE);
    step_xn_valid  = (state_q == S_ISSUE);
    step_xn1_ready = (state_q == S_WAIT);
    res_valid      = (state_q == S_DONE);
  end

  assign step_d  = d_q;
  assign step_xn = xn_q;
  assign res     = res_q;

`ifdef RECIP_NR_PERF_CNT_EN
  logic [15:0] perf_done_q, perf_stall_q;
  logic        stall;

  assign stall = (state_q == S_ISSUE && !step_xn_ready) || (state_q == S_DONE && !res_ready);

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_done_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (res_valid && res_ready && perf_done_q != 16'hFFFF) perf_done_q <= perf_done_q + 16'd1;
      if (stall && perf_stall_q != 16'hFFFF) perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  assign perf_done_cnt  = perf_done_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_recip_nr_ctrl.sv
// Directed bench for recip_nr_ctrl with a 3-cycle table-driven NR step unit model.
module tb_recip_nr_ctrl;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_d = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] step_d, step_xn, step_xn1, res;
  logic        step_xn_valid, step_xn_ready, step_xn1_valid, step_xn1_ready;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        xn_ready_en = 1'b1;
`ifdef RECIP_NR_PERF_CNT_EN
  logic [15:0] perf_done_cnt, perf_stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  recip_nr_ctrl dut (
    .clk(clk), .rst(rst),
    .in_d(in_d), .in_valid(in_valid), .in_ready(in_ready),
    .step_d(step_d), .step_xn(step_xn), .step_xn_valid(step_xn_valid),
    .step_xn_ready(step_xn_ready), .step_xn1(step_xn1),
    .step_xn1_valid(step_xn1_valid), .step_xn1_ready(step_xn1_ready),
    .res(res), .res_valid(res_valid), .res_ready(res_ready)
`ifdef RECIP_NR_PERF_CNT_EN
    , .perf_done_cnt(perf_done_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Hand-rounded bf16 results of Xn*(2-D*Xn) for the operands used here.
  function automatic logic [15:0] nr_lookup(input logic [15:0] d, input logic [15:0] x);
    case ({d, x})
      {16'h4000, 16'h3EFF}: return 16'h3F00;
      {16'h4000, 16'h3F00}: return 16'h3F00;
      {16'hC040, 16'hBEBF}: return 16'hBEA8;
      {16'hC040, 16'hBEA8}: return 16'hBEAB;
      {16'h3F80, 16'h3F7F}: return 16'h3F80;
      {16'h3F80, 16'h3F80}: return 16'h3F80;
      default:              return 16'hDEAD;
    endcase
  endfunction

  // Step unit model: one op at a time, result valid LAT cycles after the Xn handshake.
  logic        sm_busy, sm_valid;
  logic [15:0] sm_res;
  int          sm_wait;

  assign step_xn_ready  = xn_ready_en && !sm_busy;
  assign step_xn1_valid = sm_valid;
  assign step_xn1       = sm_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sm_busy <= 1'b0;
      sm_valid <= 1'b0;
      sm_res <= '0;
      sm_wait <= 0;
    end else if (step_xn1_valid && step_xn1_ready) begin
      sm_valid <= 1'b0;
      sm_busy <= 1'b0;
    end else if (sm_busy && !sm_valid) begin
      if (sm_wait <= 1) sm_valid <= 1'b1;
      sm_wait <= sm_wait - 1;
    end else if (!sm_busy && step_xn_valid && step_xn_ready) begin
      sm_busy <= 1'b1;
      sm_wait <= LAT - 1;
      sm_res <= nr_lookup(step_d, step_xn);
    end
  end

  // Handshake monitor.
  int          cyc = 0, hs_cnt = 0, xv_cnt = 0, acc_cnt = 0, done_cnt = 0;
  logic [15:0] xn_log [0:255];
  logic [15:0] d_log [0:255];
  logic [15:0] res_log [0:255];
  int          acc_log [0:255];
  int          done_log [0:255];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (step_xn_valid) xv_cnt <= xv_cnt + 1;
    if (step_xn_valid && step_xn_ready) begin
      xn_log[hs_cnt[7:0]] <= step_xn;
      d_log[hs_cnt[7:0]] <= step_d;
      hs_cnt <= hs_cnt + 1;
    end
    if (in_valid && in_ready) begin
      acc_log[acc_cnt[7:0]] <= cyc;
      acc_cnt <= acc_cnt + 1;
    end
    if (res_valid && res_ready) begin
      done_log[done_cnt[7:0]] <= cyc;
      res_log[done_cnt[7:0]] <= res;
      done_cnt <= done_cnt + 1;
    end
  end

  // One operand with res_ready=1; lat counts accept cycle through DONE cycle inclusive.
  task automatic run_op(input logic [15:0] d, output logic [15:0] r, output int lat,
                        output int hs, output int xv, output int h0);
    int k;
    int xv0;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    h0 = hs_cnt;
    xv0 = xv_cnt;
    in_d = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!res_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    lat = k + 1;
    r = res;
    @(negedge clk);
    hs = hs_cnt - h0;
    xv = xv_cnt - xv0;
  endtask

  task automatic test_reset;
    tests++;
    if ({in_ready, step_xn_valid, step_xn1_ready, res_valid} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 1000",
               {in_ready, step_xn_valid, step_xn1_ready, res_valid});
    end
    tests++;
    if ({step_d, step_xn, res} !== 48'h0) begin
      fails++;
      $display("FAIL reset_data: got %h want 0", {step_d, step_xn, res});
    end
  endtask

  task automatic test_two;
    logic [15:0] r;
    int lat, hs, xv, h0;
    run_op(16'h4000, r, lat, hs, xv, h0);
    tests++;
    if (r !== 16'h3F00) begin fails++; $display("FAIL two_res: got %h want 3f00", r); end
    tests++;
    if (lat !== 1 + 2 * (1 + LAT) + 1) begin
      fails++;
      $display("FAIL two_latency: got %0d want %0d", lat, 1 + 2 * (1 + LAT) + 1);
    end
    tests++;
    if (hs !== 2) begin fails++; $display("FAIL two_handshakes: got %0d want 2", hs); end
    tests++;
    if (xn_log[h0[7:0]] !== 16'h3EFF) begin
      fails++;
      $display("FAIL two_seed: got %h want 3eff", xn_log[h0[7:0]]);
    end
  endtask

  task automatic test_neg_three;
    logic [15:0] r;
    int lat, hs, xv, h0;
    run_op(16'hC040, r, lat, hs, xv, h0);
    tests++;
    if (r !== 16'hBEAB) begin fails++; $display("FAIL neg3_res: got %h want beab", r); end
    tests++;
    if ({d_log[h0[7:0]], d_log[8'(h0 + 1)], hs} !== {16'hC040, 16'hC040, 32'd2}) begin
      fails++;
      $display("FAIL neg3_step_d: got %h %h hs=%0d want c040 c040 hs=2",
               d_log[h0[7:0]], d_log[8'(h0 + 1)], hs);
    end
  endtask

  task automatic test_specials;
    logic [15:0] din [5] = '{16'h0000, 16'h8000, 16'h7F80, 16'h7FC1, 16'h7E80};
    logic [15:0] want [5] = '{16'h7F80, 16'hFF80, 16'h0000, 16'h7FC0, 16'h0000};
    logic [15:0] r;
    int lat, hs, xv, h0;
    for (int i = 0; i < 5; i++) begin
      run_op(din[i], r, lat, hs, xv, h0);
      tests++;
      if ({r, lat, xv} !== {want[i], 32'd2, 32'd0}) begin
        fails++;
        $display("FAIL special_%h: got res=%h lat=%0d xn_valid_cycles=%0d want res=%h lat=2 xn_valid_cycles=0",
                 din[i], r, lat, xv, want[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int k;
    logic [15:0] ps0, pd0;
    ps0 = '0;
    pd0 = '0;
    @(negedge clk);
`ifdef RECIP_NR_PERF_CNT_EN
    ps0 = perf_stall_cnt;
    pd0 = perf_done_cnt;
`endif
    xn_ready_en = 1'b0;
    res_ready = 1'b0;
    in_d = 16'h4000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) begin
      tests++;
      if ({step_xn_valid, in_ready, step_xn} !== {1'b1, 1'b0, 16'h3EFF}) begin
        fails++;
        $display("FAIL bp_issue_hold: got v=%b in_ready=%b xn=%h want v=1 in_ready=0 xn=3eff",
                 step_xn_valid, in_ready, step_xn);
      end
      @(negedge clk);
    end
    xn_ready_en = 1'b1;
    k = 0;
    while (!res_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (4) begin
      tests++;
      if ({res_valid, in_ready, res} !== {1'b1, 1'b0, 16'h3F00}) begin
        fails++;
        $display("FAIL bp_done_hold: got v=%b in_ready=%b res=%h want v=1 in_ready=0 res=3f00",
                 res_valid, in_ready, res);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({res_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL bp_release: got v=%b in_ready=%b want v=0 in_ready=1", res_valid, in_ready);
    end
`ifdef RECIP_NR_PERF_CNT_EN
    tests++;
    if ({perf_stall_cnt - ps0, perf_done_cnt - pd0} !== {16'd9, 16'd1}) begin
      fails++;
      $display("FAIL bp_perf: got stall=%0d done=%0d want stall=9 done=1",
               perf_stall_cnt - ps0, perf_done_cnt - pd0);
    end
`endif
  endtask

  task automatic test_reset_mid_op;
    int k;
    logic [15:0] r;
    int lat, hs, xv, h0;
    @(negedge clk);
    in_d = 16'h4000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!(step_xn1_valid && step_xn1_ready) && k < 50) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (!(step_xn1_valid && step_xn1_ready)) begin
      fails++;
      $display("FAIL rst_reach_wait: got %b want 1", step_xn1_valid && step_xn1_ready);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({in_ready, step_xn_valid, step_xn1_ready, res_valid, step_d, step_xn, res} !==
        {4'b1000, 48'h0}) begin
      fails++;
      $display("FAIL rst_mid_outputs: got %b %h want 1000 0",
               {in_ready, step_xn_valid, step_xn1_ready, res_valid}, {step_d, step_xn, res});
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h4000, r, lat, hs, xv, h0);
    tests++;
    if ({r, hs} !== {16'h3F00, 32'd2}) begin
      fails++;
      $display("FAIL rst_recover: got res=%h hs=%0d want res=3f00 hs=2", r, hs);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] din [4] = '{16'h4000, 16'hC040, 16'h0000, 16'h3F80};
    logic [15:0] want [4] = '{16'h3F00, 16'hBEAB, 16'h7F80, 16'h3F80};
    int a0, d0, k;
    @(negedge clk);
    a0 = acc_cnt;
    d0 = done_cnt;
    res_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_d = din[i];
      k = 0;
      while (acc_cnt == a0 + i && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    in_valid = 1'b0;
    k = 0;
    while (done_cnt < d0 + 4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (res_log[8'(d0 + i)] !== want[i] || done_cnt < d0 + 4) begin
        fails++;
        $display("FAIL b2b_res_%0d: got %h (done=%0d) want %h", i, res_log[8'(d0 + i)],
                 done_cnt - d0, want[i]);
      end
    end
    for (int i = 1; i < 4; i++) begin
      tests++;
      if (acc_log[8'(a0 + i)] !== done_log[8'(d0 + i - 1)] + 1) begin
        fails++;
        $display("FAIL b2b_accept_%0d: got cycle %0d want %0d", i, acc_log[8'(a0 + i)],
                 done_log[8'(d0 + i - 1)] + 1);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_two();
    test_neg_three();
    test_specials();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
